mem_access: RTL and testbench

Memory-access stage between the EX/MEM pipeline latch and the register file write port. It passes ALU results through to write-back. It runs LOAD/STORE transactions against external asynchronous SRAM using a wait-state FSM, and requests a pipeline stall while a transaction is in flight. Its registered outputs drive the register file write port (wEnable/wAddr/wData) directly.

---
 rtl/mem_access.sv | 121 ++++++++++++
 tb/tb_mem_access.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results to write-back, runs LOAD/STORE against async SRAM.
// Latency: ALU pass-through 1 cycle; memory ops WAIT_CYCLES+1 cycles to write-back.
// Backpressure: stallReq_o holds upstream while an SRAM transaction is in flight; no overlap.
module mem_access #(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_ADDR_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wEnable_i,
  input  logic [3:0]            wAddr_i,
  input  logic [15:0]           wData_i,
  input  logic [1:0]            memOp_i,
  input  logic [15:0]           memAddr_i,
  input  logic [15:0]           memWData_i,
  output logic                  stallReq_o,
  output logic                  wEnable_o,
  output logic [3:0]            wAddr_o,
  output logic [15:0]           wData_o,
  output logic [RAM_ADDR_W-1:0] ramAddr_o,
  output logic [15:0]           ramWData_o,
  input  logic [15:0]           ramRData_i,
  output logic                  ramCe_n_o,
  output logic                  ramOe_n_o,
  output logic                  ramWe_n_o
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  logic [0:0] state;
  logic [3:0] cnt;
  logic       op_store;
  logic       lat_wen;
  logic [3:0] lat_waddr;
  logic       is_load;
  logic       is_store;

  // Decode the incoming op; the reserved encoding 11 falls through as NONE.
  always_comb begin
    is_load  = (memOp_i == OP_LOAD);
    is_store = (memOp_i == OP_STORE);
  end

  // Stall while a transaction starts or is still running; the last ACCESS cycle
  // releases upstream so the next instruction lands in IDLE right after.
  always_comb begin
    stallReq_o = 1'b0;
    if (state == S_IDLE) begin
      stallReq_o = is_load | is_store;
    end else begin
      stallReq_o = (cnt != 4'd1);
    end
  end

  // Wait-state FSM, SRAM strobes and the registered write-back port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      op_store   <= 1'b0;
      lat_wen    <= 1'b0;
      lat_waddr  <= 4'd0;
      wEnable_o  <= 1'b0;
      wAddr_o    <= 4'd0;
      wData_o    <= 16'd0;
      ramAddr_o  <= '0;
      ramWData_o <= 16'd0;
      ramCe_n_o  <= 1'b1;
      ramOe_n_o  <= 1'b1;
      ramWe_n_o  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_load || is_store) begin
            op_store   <= is_store;
            lat_wen    <= wEnable_i;
            lat_waddr  <= wAddr_i;
            ramAddr_o  <= RAM_ADDR_W'(memAddr_i);
            ramWData_o <= memWData_i;
            ramCe_n_o  <= 1'b0;
            ramOe_n_o  <= ~is_load;
            ramWe_n_o  <= ~is_store;
            cnt        <= 4'(WAIT_CYCLES);
            state      <= S_ACCESS;
            // Bubble into write-back while the SRAM is busy.
            wEnable_o  <= 1'b0;
          end else begin
            wEnable_o <= wEnable_i;
            wAddr_o   <= wAddr_i;
            wData_o   <= wData_i;
          end
        end
        default: begin
          cnt <= cnt - 4'd1;
          // Release WE one cycle early so the final cycle holds address/data with WE high.
          if (op_store && (cnt == 4'd2)) begin
            ramWe_n_o <= 1'b1;
          end
          if (cnt == 4'd1) begin
            state     <= S_IDLE;
            ramCe_n_o <= 1'b1;
            ramOe_n_o <= 1'b1;
            ramWe_n_o <= 1'b1;
            if (op_store) begin
              wEnable_o <= 1'b0;
            end else begin
              wEnable_o <= lat_wen;
              wAddr_o   <= lat_waddr;
              wData_o   <= ramRData_i;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: scoreboarded write-back and SRAM strobe checks,
// with a behavioural async SRAM and a reference memory image.
module tb_mem_access;

  localparam int W   = 3;
  localparam int RAW = 18;

  logic            clk = 1'b0;
  logic            rst;
  logic            wEnable_i;
  logic [3:0]      wAddr_i;
  logic [15:0]     wData_i;
  logic [1:0]      memOp_i;
  logic [15:0]     memAddr_i;
  logic [15:0]     memWData_i;
  logic            stallReq_o;
  logic            wEnable_o;
  logic [3:0]      wAddr_o;
  logic [15:0]     wData_o;
  logic [RAW-1:0]  ramAddr_o;
  logic [15:0]     ramWData_o;
  logic [15:0]     ramRData_i = 16'h0;
  logic            ramCe_n_o;
  logic            ramOe_n_o;
  logic            ramWe_n_o;

  mem_access #(.WAIT_CYCLES(W), .RAM_ADDR_W(RAW)) dut (
    .clk(clk), .rst(rst),
    .wEnable_i(wEnable_i), .wAddr_i(wAddr_i), .wData_i(wData_i),
    .memOp_i(memOp_i), .memAddr_i(memAddr_i), .memWData_i(memWData_i),
    .stallReq_o(stallReq_o),
    .wEnable_o(wEnable_o), .wAddr_o(wAddr_o), .wData_o(wData_o),
    .ramAddr_o(ramAddr_o), .ramWData_o(ramWData_o), .ramRData_i(ramRData_i),
    .ramCe_n_o(ramCe_n_o), .ramOe_n_o(ramOe_n_o), .ramWe_n_o(ramWe_n_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string nm, input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", nm, msg);
    end
  endtask

  // Async SRAM: write lands when WE rises while CE is still low; reads follow OE.
  logic [15:0] sram    [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic        we_prev = 1'b1;
  always @(negedge clk) begin
    if (!ramCe_n_o && ramWe_n_o && !we_prev) sram[ramAddr_o[15:0]] = ramWData_o;
    we_prev    = ramWe_n_o | ramCe_n_o;
    ramRData_i = (!ramCe_n_o && !ramOe_n_o) ? sram[ramAddr_o[15:0]] : 16'h0000;
  end

  typedef struct { int cyc; logic [3:0] a; logic [15:0] d; } wb_t;
  typedef struct { int start; logic [15:0] addr; logic [15:0] data; bit store; } tx_t;
  wb_t wbq[$];
  tx_t txq[$];

  // Write-back monitor: every asserted wEnable_o must match the next expected result, on time.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wbq.size() > 0 && wbq[0].cyc < cyc) begin
        check("wb_on_time", 1'b0, $sformatf("expected r%0d=%h at cycle %0d, no write observed", wbq[0].a, wbq[0].d, wbq[0].cyc));
        void'(wbq.pop_front());
      end
      if (wEnable_o) begin
        check("wb_expected", wbq.size() > 0, $sformatf("unexpected write r%0d=%h at cycle %0d", wAddr_o, wData_o, cyc));
        if (wbq.size() > 0) begin
          wb_t e;
          e = wbq.pop_front();
          check("writeback", e.cyc == cyc && wAddr_o == e.a && wData_o == e.d,
                $sformatf("got r%0d=%h @%0d, want r%0d=%h @%0d", wAddr_o, wData_o, cyc, e.a, e.d, e.cyc));
        end
      end
    end
  end

  // SRAM strobe monitor: each transaction owns cycles start..start+W-1 exactly.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!ramCe_n_o) begin
        check("sram_expected", txq.size() > 0, $sformatf("CE low with no transaction at cycle %0d", cyc));
        if (txq.size() > 0) begin
          tx_t f;
          int  k;
          logic exp_we;
          f      = txq[0];
          k      = cyc - f.start + 1;
          exp_we = !(f.store && k < W);
          check("sram_cycle",
                k >= 1 && k <= W && ramAddr_o == {2'b00, f.addr} && ramWData_o == f.data &&
                ramOe_n_o == f.store && ramWe_n_o == exp_we && !wEnable_o,
                $sformatf("k=%0d addr=%h/%h wdat=%h/%h oe=%b/%b we=%b/%b wen=%b/0", k, ramAddr_o, f.addr,
                          ramWData_o, f.data, ramOe_n_o, f.store, ramWe_n_o, exp_we, wEnable_o));
          if (k >= W) void'(txq.pop_front());
        end
      end else begin
        check("sram_idle", ramOe_n_o && ramWe_n_o && (txq.size() == 0 || cyc < txq[0].start),
              $sformatf("cycle %0d oe=%b we=%b pending=%0d, want idle strobes 1 and no late start",
                        cyc, ramOe_n_o, ramWe_n_o, txq.size()));
      end
    end
  end

  // Present one instruction (called #1 after a rising edge), update the model, and hold it until accepted.
  task automatic issue(input logic [1:0] op, input logic wen, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [15:0] ma, input logic [15:0] md);
    int t;
    int k;
    bit ld, st, mem, done, exp_stall;
    memOp_i    = op;
    wEnable_i  = wen;
    wAddr_i    = wa;
    wData_i    = wd;
    memAddr_i  = ma;
    memWData_i = md;
    t   = cyc;
    ld  = (op == 2'b01);
    st  = (op == 2'b10);
    mem = ld || st;
    if (!mem) begin
      if (wen) wbq.push_back('{t + 1, wa, wd});
    end else begin
      txq.push_back('{t + 1, ma, md, st});
      if (ld && wen) wbq.push_back('{t + W + 1, wa, ref_mem[ma]});
      if (st) ref_mem[ma] = md;
    end
    k    = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      exp_stall = mem && (k < W);
      check("stall", stallReq_o == exp_stall,
            $sformatf("op=%0d offset=%0d stall=%b want %b", op, k, stallReq_o, exp_stall));
      if (!stallReq_o || k > W + 4) done = 1;
      k++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int mism;
    logic [15:0] keep40;
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = 16'(i * 7 + 3);
      ref_mem[i] = sram[i];
    end

    // Reset with a pending LOAD on the inputs: reset must win.
    rst = 1'b1; memOp_i = 2'b01; wEnable_i = 1'b1; wAddr_i = 4'hF;
    wData_i = 16'hFFFF; memAddr_i = 16'hFFFF; memWData_i = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_wb", wEnable_o == 1'b0 && wAddr_o == 4'h0 && wData_o == 16'h0,
          $sformatf("wen=%b waddr=%h wdata=%h, want 0/0/0", wEnable_o, wAddr_o, wData_o));
    check("reset_ram", ramAddr_o == '0 && ramWData_o == 16'h0,
          $sformatf("ramAddr=%h ramWData=%h, want 0/0", ramAddr_o, ramWData_o));
    check("reset_strobes", ramCe_n_o && ramOe_n_o && ramWe_n_o,
          $sformatf("ce=%b oe=%b we=%b, want 111", ramCe_n_o, ramOe_n_o, ramWe_n_o));
    memOp_i = 2'b00;
    #1;
    check("reset_stall", stallReq_o == 1'b0, $sformatf("stall=%b want 0", stallReq_o));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed cases.
    issue(2'b00, 1'b1, 4'd3, 16'h1234, 16'h0, 16'h0);
    sram[16'h8001] = 16'hBEEF; ref_mem[16'h8001] = 16'hBEEF;
    issue(2'b01, 1'b1, 4'd5, 16'h0, 16'h8001, 16'h0);
    issue(2'b10, 1'b0, 4'd0, 16'h0, 16'h0010, 16'h00FF);
    check("store_0010", sram[16'h0010] == 16'h00FF, $sformatf("sram[0010]=%h want 00ff", sram[16'h0010]));
    issue(2'b10, 1'b0, 4'd0, 16'h0, 16'h0020, 16'hAAAA);
    issue(2'b01, 1'b1, 4'd7, 16'h0, 16'h0020, 16'h0);
    issue(2'b11, 1'b1, 4'd9, 16'h5555, 16'h0030, 16'h1111);
    issue(2'b01, 1'b1, 4'd0, 16'h0, 16'h0010, 16'h0);

    // Randomized mix, addresses clustered so loads often hit earlier stores.
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            16'($urandom), a, 16'($urandom));
    end

    // Reset in the first ACCESS cycle of a STORE: strobes drop, nothing is written.
    issue(2'b00, 1'b0, 4'd0, 16'h0, 16'h0, 16'h0);
    mon_en = 1'b0;
    keep40 = sram[16'h0040];
    memOp_i = 2'b10; memAddr_i = 16'h0040; memWData_i = 16'h1357; wEnable_i = 1'b1; wAddr_i = 4'd2;
    @(posedge clk);
    #1;
    rst = 1'b1; memOp_i = 2'b00; wEnable_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_strobes", ramCe_n_o && ramOe_n_o && ramWe_n_o,
          $sformatf("ce=%b oe=%b we=%b, want 111", ramCe_n_o, ramOe_n_o, ramWe_n_o));
    check("abort_wb", wEnable_o == 1'b0 && stallReq_o == 1'b0,
          $sformatf("wen=%b stall=%b, want 0/0", wEnable_o, stallReq_o));
    @(posedge clk);
    #1;
    check("abort_nowrite", sram[16'h0040] == keep40, $sformatf("sram[0040]=%h want %h", sram[16'h0040], keep40));
    mon_en = 1'b1;
    issue(2'b00, 1'b1, 4'd6, 16'hC0DE, 16'h0, 16'h0);
    issue(2'b01, 1'b1, 4'd4, 16'h0, 16'h0020, 16'h0);
    issue(2'b00, 1'b0, 4'd0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;

    check("drain_wb", wbq.size() == 0, $sformatf("%0d write-backs outstanding, want 0", wbq.size()));
    check("drain_sram", txq.size() == 0, $sformatf("%0d SRAM transactions outstanding, want 0", txq.size()));
    mism = 0;
    for (int i = 0; i < 65536; i++) if (sram[i] != ref_mem[i]) mism++;
    check("mem_image", mism == 0, $sformatf("%0d SRAM words differ from reference, want 0", mism));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
